peak_dpu_iss: RTL and testbench
===============================

Name: peak_dpu_iss

Overview:
Single-issue scheduler between the instr0 decoder and the execution units (ALU, MUL, DIV, LS, BR).
- Tracks pending GPR writes in a 32-entry scoreboard and stalls on RAW/WAW hazards.
- Holds a one-entry issue register and dispatches to the target unit with a valid/ready handshake.
- Bounds outstanding loads/stores and retires scoreboard entries on writeback.

Parameters:
LS_MAX_OUTST, 2, maximum LS operations issued but not yet completed (1..7)
NREG, 32, GPR count; x0 is never tracked

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (branch mispredict/trap); kills the held issue entry
instr0_vld  in  1  decoded instruction valid
instr0_rdy  out  1  scheduler accepts instr0 this cycle
instr0_unit  in  5  one-hot {br,ls,div,mul,alu} from decoder is_* flags
instr0_fn  in  4  unit op (alu_op, or mul/div/ls/br op zero-extended)
instr0_rd_vld  in  3  read-port valids r2..r0
instr0_rd_addr  in  15  {r2,r1,r0} addresses, 5 bits each
instr0_wr_vld  in  1  destination write valid
instr0_wr_addr  in  5  destination register
instr0_imm  in  32  immediate
instr0_use_imm  in  1  immediate selects operand
iss_vld  out  1  issue register valid
iss_unit  out  5  one-hot target unit
iss_fn / iss_rd_addr / iss_wr_vld / iss_wr_addr / iss_imm / iss_use_imm  out  4/15/1/5/32/1  registered copies
unit_rdy  in  5  per-unit ready, same bit order as iss_unit
wb0_vld, wb0_addr  in  1, 5  writeback port 0 (ALU/MUL/BR)
wb1_vld, wb1_addr  in  1, 5  writeback port 1 (LS/DIV)
ls_done  in  1  one LS operation completed (with or without writeback)
stall_cause  out  2  0 none, 1 RAW/WAW, 2 unit busy/issue full, 3 LS limit

Behaviour:
Reset: pend = 0, ls_cnt = 0, iss_vld = 0, all other iss_* = 0, stall_cause = 0.

Issue and accept:
- iss_fire = iss_vld & |(iss_unit & unit_rdy).
- slot_free = ~iss_vld | iss_fire.
- clr_mask = one-hot(wb0_addr) & wb0_vld | one-hot(wb1_addr) & wb1_vld, with bit 0 forced 0.
- pend_eff = pend & ~clr_mask. Writeback is bypassed into the hazard check in the same cycle.
- haz = any rd_vld[i] with rd_addr[i] != 0 and pend_eff[rd_addr[i]]; or wr_vld with wr_addr != 0 and pend_eff[wr_addr].
- ls_block = instr0_unit[ls] & (ls_cnt + (iss_vld & iss_unit[ls] ? 1 : 0) >= LS_MAX_OUTST).
- instr0_rdy = slot_free & ~haz & ~ls_block & ~flush. The instr0_vld → instr0_rdy path is combinational.
- Accept (instr0_vld & instr0_rdy): load the issue register, iss_vld = 1 next cycle, so latency is 1 cycle decoder → unit.
- If the slot is not free, iss_* hold stable until iss_fire.
- Back-to-back accept and fire in the same cycle is allowed (full throughput, 1 instr/cycle).

Scoreboard:
- Next pend = (pend & ~clr_mask) | set_mask, where set_mask is one-hot(instr0_wr_addr) on accept with wr_vld and wr_addr != 0.
- Set and clear of the same register in one cycle: set wins.
- wb0 and wb1 to the same address: single clear.
- Writeback to a non-pending register is ignored.

LS counter:
- +1 on iss_fire with iss_unit[ls]; −1 on ls_done; both in one cycle → unchanged.
- ls_done with ls_cnt = 0 is ignored (no underflow).
- By construction ls_cnt never exceeds LS_MAX_OUTST.

Flush (async to instruction flow, synchronous effect):
- Next cycle iss_vld = 0.
- If the killed entry had wr_vld, its pend bit is cleared unless it is re-set that cycle (re-set cannot happen, since instr0_rdy = 0).
- A flush that coincides with iss_fire: the fire completes and the unit owns the instruction. Its pend bit stays set and is cleared by the unit's writeback.
- Already-issued operations are unaffected; ls_cnt is unaffected.

stall_cause:
- Registered, updated each cycle instr0_vld is high and instr0_rdy is low; 0 otherwise.
- Priority when several causes apply: 1, then 3, then 2.

Asynchronous reset mid-operation returns everything to the reset values immediately; in-flight writebacks arriving after reset are ignored as non-pending.

Decomposition:
- Shared package peak_dpu_pkg holds:
  - unit one-hot bit indices (ALU=0, MUL=1, DIV=2, LS=3, BR=4);
  - stall_cause encodings;
  - fn width 4.
- One natural sub-module, peak_dpu_iss_sb: scoreboard register, clr/set masks, 4-way hazard lookup.
- Issue register, LS counter and flush handling stay in the top.

Test Plan:
1. ALU "x5 ← x1+x2" accepted at cycle 0, followed by "x6 ← x5+x3" → second instr stalls (instr0_rdy = 0, stall_cause = 1) until wb0 x5 arrives. It is accepted that same cycle via bypass, and iss_vld rises the next cycle.
2. unit_rdy[div] = 0 for 5 cycles with a DIV held → iss_* stable, instr0_rdy = 0, stall_cause = 2. On unit_rdy rising, the fire and the next accept happen in the same cycle.
3. LS_MAX_OUTST = 2: three back-to-back loads to x7, x8, x9 with no ls_done → third stalls with stall_cause = 3. One ls_done pulse lets it issue, and ls_cnt returns to 2.
4. Flush while a MUL writing x10 is held and unit_rdy = 0 → iss_vld = 0 next cycle, pend[x10] = 0, and a following read of x10 is not stalled.
5. Same-cycle wb1 x4 and accept of a new writer to x4 → pend[x4] remains 1. wb0 and wb1 both to x3 → pend[x3] = 0, and x0 writes never set pend.
6. Assert rst_n low mid-stream with pend = 0xF0 and ls_cnt = 2 → all outputs are zero immediately. After release, a stale wb of x4 and an ls_done are ignored.

Source files
------------

// File: rtl/peak_dpu_pkg.sv
// Shared definitions for the peak_dpu issue stage: unit indices, stall encodings, widths.
package peak_dpu_pkg;
    localparam int NUNIT  = 5;
    localparam int NREG   = 32;
    localparam int FN_W   = 4;

    localparam int U_ALU  = 0;
    localparam int U_MUL  = 1;
    localparam int U_DIV  = 2;
    localparam int U_LS   = 3;
    localparam int U_BR   = 4;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_HAZ  = 2'd1,
        STALL_BUSY = 2'd2,
        STALL_LS   = 2'd3
    } stall_e;
endpackage

// File: rtl/peak_dpu_iss_sb.sv
// GPR pending-write scoreboard with same-cycle writeback bypass into the hazard lookup.
module peak_dpu_iss_sb
    import peak_dpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb0_vld,
    input  logic [4:0]  wb0_addr,
    input  logic        wb1_vld,
    input  logic [4:0]  wb1_addr,
    input  logic        set_vld,
    input  logic [4:0]  set_addr,
    input  logic        kill_vld,
    input  logic [4:0]  kill_addr,
    input  logic [2:0]  rd_vld,
    input  logic [14:0] rd_addr,
    input  logic        wr_vld,
    input  logic [4:0]  wr_addr,
    output logic        haz
);
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] clr_mask, set_mask, kill_mask, pend_eff;

    always_comb begin
        clr_mask  = '0;
        set_mask  = '0;
        kill_mask = '0;
        if (wb0_vld)  clr_mask[wb0_addr]  = 1'b1;
        if (wb1_vld)  clr_mask[wb1_addr]  = 1'b1;
        if (set_vld)  set_mask[set_addr]  = 1'b1;
        if (kill_vld) kill_mask[kill_addr] = 1'b1;
        clr_mask[0]  = 1'b0;
        set_mask[0]  = 1'b0;
        kill_mask[0] = 1'b0;
        pend_eff = pend_q & ~clr_mask;
        // set last so a same-cycle writeback of the new destination cannot drop it
        pend_d   = (pend_eff & ~kill_mask) | set_mask;
    end

    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rd_vld[i] && (rd_addr[i*5 +: 5] != 5'd0) && pend_eff[rd_addr[i*5 +: 5]])
                haz = 1'b1;
        end
        if (wr_vld && (wr_addr != 5'd0) && pend_eff[wr_addr])
            haz = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end
endmodule

// File: rtl/peak_dpu_iss.sv
// Single-issue scheduler: hazard-checked accept into a one-entry issue register,
// valid/ready dispatch to the execution units, and bounded outstanding load/store count.
module peak_dpu_iss
    import peak_dpu_pkg::*;
#(
    parameter int LS_MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            instr0_vld,
    output logic            instr0_rdy,
    input  logic [4:0]      instr0_unit,
    input  logic [FN_W-1:0] instr0_fn,
    input  logic [2:0]      instr0_rd_vld,
    input  logic [14:0]     instr0_rd_addr,
    input  logic            instr0_wr_vld,
    input  logic [4:0]      instr0_wr_addr,
    input  logic [31:0]     instr0_imm,
    input  logic            instr0_use_imm,
    output logic            iss_vld,
    output logic [4:0]      iss_unit,
    output logic [FN_W-1:0] iss_fn,
    output logic [14:0]     iss_rd_addr,
    output logic            iss_wr_vld,
    output logic [4:0]      iss_wr_addr,
    output logic [31:0]     iss_imm,
    output logic            iss_use_imm,
    input  logic [4:0]      unit_rdy,
    input  logic            wb0_vld,
    input  logic [4:0]      wb0_addr,
    input  logic            wb1_vld,
    input  logic [4:0]      wb1_addr,
    input  logic            ls_done,
    output logic [1:0]      stall_cause
);
    logic            iss_vld_q, iss_vld_d;
    logic [4:0]      iss_unit_q, iss_unit_d;
    logic [FN_W-1:0] iss_fn_q, iss_fn_d;
    logic [14:0]     iss_rd_addr_q, iss_rd_addr_d;
    logic            iss_wr_vld_q, iss_wr_vld_d;
    logic [4:0]      iss_wr_addr_q, iss_wr_addr_d;
    logic [31:0]     iss_imm_q, iss_imm_d;
    logic            iss_use_imm_q, iss_use_imm_d;
    logic [2:0]      ls_cnt_q, ls_cnt_d;
    stall_e          stall_q, stall_d;

    logic       iss_fire, slot_free, haz, ls_block, accept, kill_vld, ls_inc, ls_dec;
    logic [3:0] ls_pend;

    assign iss_fire   = iss_vld_q & |(iss_unit_q & unit_rdy);
    assign slot_free  = ~iss_vld_q | iss_fire;
    // the held LS op counts against the limit before it has actually fired
    assign ls_pend    = {1'b0, ls_cnt_q} + {3'b000, iss_vld_q & iss_unit_q[U_LS]};
    assign ls_block   = instr0_unit[U_LS] & (ls_pend >= 4'(LS_MAX_OUTST));
    assign instr0_rdy = slot_free & ~haz & ~ls_block & ~flush;
    assign accept     = instr0_vld & instr0_rdy;
    assign kill_vld   = flush & iss_vld_q & ~iss_fire & iss_wr_vld_q;
    assign ls_inc     = iss_fire & iss_unit_q[U_LS];
    assign ls_dec     = ls_done & (ls_cnt_q != 3'd0);

    peak_dpu_iss_sb u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb0_vld  (wb0_vld),
        .wb0_addr (wb0_addr),
        .wb1_vld  (wb1_vld),
        .wb1_addr (wb1_addr),
        .set_vld  (accept & instr0_wr_vld),
        .set_addr (instr0_wr_addr),
        .kill_vld (kill_vld),
        .kill_addr(iss_wr_addr_q),
        .rd_vld   (instr0_rd_vld),
        .rd_addr  (instr0_rd_addr),
        .wr_vld   (instr0_wr_vld),
        .wr_addr  (instr0_wr_addr),
        .haz      (haz)
    );

    always_comb begin
        iss_vld_d     = iss_vld_q;
        iss_unit_d    = iss_unit_q;
        iss_fn_d      = iss_fn_q;
        iss_rd_addr_d = iss_rd_addr_q;
        iss_wr_vld_d  = iss_wr_vld_q;
        iss_wr_addr_d = iss_wr_addr_q;
        iss_imm_d     = iss_imm_q;
        iss_use_imm_d = iss_use_imm_q;
        if (flush) begin
            iss_vld_d = 1'b0;
        end else if (accept) begin
            iss_vld_d     = 1'b1;
            iss_unit_d    = instr0_unit;
            iss_fn_d      = instr0_fn;
            iss_rd_addr_d = instr0_rd_addr;
            iss_wr_vld_d  = instr0_wr_vld;
            iss_wr_addr_d = instr0_wr_addr;
            iss_imm_d     = instr0_imm;
            iss_use_imm_d = instr0_use_imm;
        end else if (iss_fire) begin
            iss_vld_d = 1'b0;
        end
    end

    always_comb begin
        ls_cnt_d = ls_cnt_q;
        if (ls_inc && !ls_dec)      ls_cnt_d = ls_cnt_q + 3'd1;
        else if (!ls_inc && ls_dec) ls_cnt_d = ls_cnt_q - 3'd1;
    end

    always_comb begin
        stall_d = STALL_NONE;
        if (instr0_vld && !instr0_rdy) begin
            if (haz)           stall_d = STALL_HAZ;
            else if (ls_block) stall_d = STALL_LS;
            else               stall_d = STALL_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_q     <= 1'b0;
            iss_unit_q    <= '0;
            iss_fn_q      <= '0;
            iss_rd_addr_q <= '0;
            iss_wr_vld_q  <= 1'b0;
            iss_wr_addr_q <= '0;
            iss_imm_q     <= '0;
            iss_use_imm_q <= 1'b0;
            ls_cnt_q      <= '0;
            stall_q       <= STALL_NONE;
        end else begin
            iss_vld_q     <= iss_vld_d;
            iss_unit_q    <= iss_unit_d;
            iss_fn_q      <= iss_fn_d;
            iss_rd_addr_q <= iss_rd_addr_d;
            iss_wr_vld_q  <= iss_wr_vld_d;
            iss_wr_addr_q <= iss_wr_addr_d;
            iss_imm_q     <= iss_imm_d;
            iss_use_imm_q <= iss_use_imm_d;
            ls_cnt_q      <= ls_cnt_d;
            stall_q       <= stall_d;
        end
    end

    assign iss_vld     = iss_vld_q;
    assign iss_unit    = iss_unit_q;
    assign iss_fn      = iss_fn_q;
    assign iss_rd_addr = iss_rd_addr_q;
    assign iss_wr_vld  = iss_wr_vld_q;
    assign iss_wr_addr = iss_wr_addr_q;
    assign iss_imm     = iss_imm_q;
    assign iss_use_imm = iss_use_imm_q;
    assign stall_cause = stall_q;
endmodule

// File: tb/tb_peak_dpu_iss.sv
// Scoreboard bench for peak_dpu_iss: directed scenarios plus randomized traffic vs a set-based model.
module tb_peak_dpu_iss;
    import peak_dpu_pkg::*;

    localparam int LSM = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        instr0_vld = 1'b0;
    logic        instr0_rdy;
    logic [4:0]  instr0_unit = '0;
    logic [3:0]  instr0_fn = '0;
    logic [2:0]  instr0_rd_vld = '0;
    logic [14:0] instr0_rd_addr = '0;
    logic        instr0_wr_vld = 1'b0;
    logic [4:0]  instr0_wr_addr = '0;
    logic [31:0] instr0_imm = '0;
    logic        instr0_use_imm = 1'b0;
    logic        iss_vld;
    logic [4:0]  iss_unit;
    logic [3:0]  iss_fn;
    logic [14:0] iss_rd_addr;
    logic        iss_wr_vld;
    logic [4:0]  iss_wr_addr;
    logic [31:0] iss_imm;
    logic        iss_use_imm;
    logic [4:0]  unit_rdy = '0;
    logic        wb0_vld = 1'b0;
    logic [4:0]  wb0_addr = '0;
    logic        wb1_vld = 1'b0;
    logic [4:0]  wb1_addr = '0;
    logic        ls_done = 1'b0;
    logic [1:0]  stall_cause;

    always #5 clk = ~clk;

    peak_dpu_iss #(.LS_MAX_OUTST(LSM)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr0_vld(instr0_vld), .instr0_rdy(instr0_rdy), .instr0_unit(instr0_unit),
        .instr0_fn(instr0_fn), .instr0_rd_vld(instr0_rd_vld), .instr0_rd_addr(instr0_rd_addr),
        .instr0_wr_vld(instr0_wr_vld), .instr0_wr_addr(instr0_wr_addr), .instr0_imm(instr0_imm),
        .instr0_use_imm(instr0_use_imm),
        .iss_vld(iss_vld), .iss_unit(iss_unit), .iss_fn(iss_fn), .iss_rd_addr(iss_rd_addr),
        .iss_wr_vld(iss_wr_vld), .iss_wr_addr(iss_wr_addr), .iss_imm(iss_imm), .iss_use_imm(iss_use_imm),
        .unit_rdy(unit_rdy), .wb0_vld(wb0_vld), .wb0_addr(wb0_addr), .wb1_vld(wb1_vld), .wb1_addr(wb1_addr),
        .ls_done(ls_done), .stall_cause(stall_cause)
    );

    typedef struct {
        logic [4:0]  unit;
        logic [3:0]  fn;
        logic [2:0]  rdv;
        logic [14:0] ra;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] imm;
        logic        ui;
    } ins_t;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state: set of pending registers, outstanding LS count, held instruction
    bit [31:0]   m_pend;
    int          m_ls;
    bit          m_vld;
    ins_t        m_h;
    int          m_stall;
    logic [62:0] exp_q[$];
    logic        s_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [62:0] pk(input ins_t i);
        return {i.unit, i.fn, i.ra, i.wv, i.wa, i.imm, i.ui};
    endfunction

    function automatic ins_t mk(input int u, input logic [2:0] rdv, input int r2, input int r1,
                                input int r0, input logic wv, input int wa);
        ins_t i;
        i.unit = 5'(1 << u);
        i.fn   = 4'($urandom_range(0, 15));
        i.rdv  = rdv;
        i.ra   = {5'(r2), 5'(r1), 5'(r0)};
        i.wv   = wv;
        i.wa   = 5'(wa);
        i.imm  = $urandom;
        i.ui   = 1'($urandom_range(0, 1));
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom_range(0, 4), 3'($urandom_range(0, 7)), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        m_pend = '0; m_ls = 0; m_vld = 0; m_stall = 0;
        exp_q.delete();
    endtask

    // monitor: whenever the DUT hands an instruction to a ready unit, it must be the oldest accepted one
    always @(negedge clk) begin
        if (rst_n && iss_vld && ((iss_unit & unit_rdy) != 5'd0)) begin
            if (exp_q.size() == 0) begin
                chk("fire_without_accept", 64'(1), 64'(0));
            end else begin
                chk("issued_instr",
                    64'({iss_unit, iss_fn, iss_rd_addr, iss_wr_vld, iss_wr_addr, iss_imm, iss_use_imm}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input ins_t in, input bit vld, input logic [4:0] urdy,
                        input bit w0v, input int w0a, input bit w1v, input int w1a,
                        input bit lsd, input bit fl);
        bit [31:0] clr, eff;
        bit haz, lsblk, rdy, fire, acc;
        int a, lsheld;
        @(posedge clk);
        #1;
        instr0_vld = vld; instr0_unit = in.unit; instr0_fn = in.fn; instr0_rd_vld = in.rdv;
        instr0_rd_addr = in.ra; instr0_wr_vld = in.wv; instr0_wr_addr = in.wa;
        instr0_imm = in.imm; instr0_use_imm = in.ui; unit_rdy = urdy;
        wb0_vld = w0v; wb0_addr = 5'(w0a); wb1_vld = w1v; wb1_addr = 5'(w1a);
        ls_done = lsd; flush = fl;
        @(negedge clk);
        #2;
        chk("iss_vld", 64'(iss_vld), 64'(m_vld));
        chk("stall_cause", 64'(stall_cause), 64'(m_stall));
        fire = m_vld && ((m_h.unit & urdy) != 0);
        clr = '0;
        if (w0v && w0a != 0) clr[w0a] = 1;
        if (w1v && w1a != 0) clr[w1a] = 1;
        eff = m_pend & ~clr;
        haz = 0;
        for (int i = 0; i < 3; i++) begin
            a = int'(in.ra[i*5 +: 5]);
            if (in.rdv[i] && a != 0 && eff[a]) haz = 1;
        end
        if (in.wv && in.wa != 0 && eff[in.wa]) haz = 1;
        lsheld = (m_vld && m_h.unit[U_LS]) ? 1 : 0;
        lsblk = in.unit[U_LS] && (m_ls + lsheld >= LSM);
        rdy = (!m_vld || fire) && !haz && !lsblk && !fl;
        s_rdy = instr0_rdy;
        chk("instr0_rdy", 64'(instr0_rdy), 64'(rdy));
        acc = vld && rdy;
        m_stall = (vld && !rdy) ? (haz ? 1 : (lsblk ? 3 : 2)) : 0;
        m_pend = eff;
        if (fl && m_vld && !fire && m_h.wv && m_h.wa != 0) m_pend[m_h.wa] = 0;
        if (acc && in.wv && in.wa != 0) m_pend[in.wa] = 1;
        if (lsd && m_ls > 0) m_ls--;
        if (fire && m_h.unit[U_LS]) m_ls++;
        if (fl) begin
            if (m_vld && !fire) void'(exp_q.pop_back());
            m_vld = 0;
        end else if (acc) begin
            m_vld = 1; m_h = in;
            exp_q.push_back(pk(in));
        end else if (fire) begin
            m_vld = 0;
        end
    endtask

    ins_t nop;

    task automatic idle(input int n, input logic [4:0] urdy);
        for (int i = 0; i < n; i++) step(nop, 0, urdy, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_iss_vld", 64'(iss_vld), 64'(0));
        chk("rst_iss_fields",
            64'({iss_unit, iss_fn, iss_rd_addr, iss_wr_vld, iss_wr_addr, iss_imm, iss_use_imm}), 64'(0));
        chk("rst_stall", 64'(stall_cause), 64'(0));
        instr0_vld = 0; flush = 0; wb0_vld = 0; wb1_vld = 0; ls_done = 0; unit_rdy = '0;
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        nop = mk(U_ALU, 3'b000, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        rst_n = 1'b1;
        chk("init_iss_vld", 64'(iss_vld), 64'(0));
        chk("init_stall", 64'(stall_cause), 64'(0));

        // 1: RAW stall resolved by same-cycle writeback bypass
        step(mk(U_ALU, 3'b011, 0, 2, 1, 1, 5), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t1_first_acc", 64'(s_rdy), 64'(1));
        step(mk(U_ALU, 3'b011, 0, 3, 5, 1, 6), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t1_raw_stall", 64'(s_rdy), 64'(0));
        step(mk(U_ALU, 3'b011, 0, 3, 5, 1, 6), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t1_raw_cause", 64'(stall_cause), 64'(STALL_HAZ));
        step(mk(U_ALU, 3'b011, 0, 3, 5, 1, 6), 1, 5'h1f, 1, 5, 0, 0, 0, 0);
        chk("t1_bypass_acc", 64'(s_rdy), 64'(1));
        idle(2, 5'h1f);
        do_reset();

        // 2: DIV held for 5 cycles, then fire and next accept together
        step(mk(U_DIV, 3'b001, 0, 0, 1, 1, 11), 1, 5'h1b, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(mk(U_ALU, 3'b001, 0, 0, 2, 1, 12), 1, 5'h1b, 0, 0, 0, 0, 0, 0);
            chk("t2_held_unit", 64'(iss_unit), 64'(5'h04));
            chk("t2_busy_rdy", 64'(s_rdy), 64'(0));
        end
        chk("t2_busy_cause", 64'(stall_cause), 64'(STALL_BUSY));
        step(mk(U_ALU, 3'b001, 0, 0, 2, 1, 12), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t2_fire_and_acc", 64'(s_rdy), 64'(1));
        idle(2, 5'h1f);
        do_reset();

        // 3: LS outstanding limit
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 7), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 8), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t3_second_ld", 64'(s_rdy), 64'(1));
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 9), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 9), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t3_third_blocked", 64'(s_rdy), 64'(0));
        chk("t3_ls_cause", 64'(stall_cause), 64'(STALL_LS));
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 9), 1, 5'h1f, 0, 0, 0, 0, 1, 0);
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 9), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t3_third_issues", 64'(s_rdy), 64'(1));
        idle(1, 5'h1f);
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 12), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t3_cnt_back_at_max", 64'(s_rdy), 64'(0));
        do_reset();

        // 4: flush kills a held MUL writing x10
        step(mk(U_MUL, 3'b001, 0, 0, 1, 1, 10), 1, 5'h1d, 0, 0, 0, 0, 0, 0);
        idle(1, 5'h1d);
        step(nop, 0, 5'h1d, 0, 0, 0, 0, 0, 1);
        step(mk(U_ALU, 3'b001, 0, 0, 10, 1, 13), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t4_flush_vld", 64'(iss_vld), 64'(0));
        chk("t4_x10_free", 64'(s_rdy), 64'(1));
        idle(2, 5'h1f);
        do_reset();

        // 5: set beats clear, dual clear of the same reg, x0 never tracked
        step(mk(U_ALU, 3'b000, 0, 0, 0, 1, 4), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_ALU, 3'b000, 0, 0, 0, 1, 4), 1, 5'h1f, 0, 0, 1, 4, 0, 0);
        chk("t5_waw_bypass", 64'(s_rdy), 64'(1));
        step(mk(U_ALU, 3'b001, 0, 0, 4, 0, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t5_x4_still_pend", 64'(s_rdy), 64'(0));
        step(mk(U_ALU, 3'b000, 0, 0, 0, 1, 3), 1, 5'h1f, 1, 4, 0, 0, 0, 0);
        step(nop, 0, 5'h1f, 1, 3, 1, 3, 0, 0);
        step(mk(U_ALU, 3'b001, 0, 0, 3, 0, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t5_x3_cleared", 64'(s_rdy), 64'(1));
        step(mk(U_ALU, 3'b000, 0, 0, 0, 1, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_ALU, 3'b111, 0, 0, 0, 1, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        chk("t5_x0_untracked", 64'(s_rdy), 64'(1));
        idle(2, 5'h1f);

        // 6: reset mid-stream with x4..x7 pending and two LS outstanding
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 4), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_LS, 3'b001, 0, 0, 1, 1, 5), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_ALU, 3'b001, 0, 0, 1, 1, 6), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_ALU, 3'b001, 0, 0, 1, 1, 7), 1, 5'h07, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(mk(U_LS, 3'b111, 7, 6, 5, 1, 4), 1, 5'h1f, 1, 4, 0, 0, 1, 0);
        chk("t6_post_rst_acc", 64'(s_rdy), 64'(1));
        step(mk(U_LS, 3'b001, 0, 0, 4, 0, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        step(mk(U_LS, 3'b001, 0, 0, 1, 0, 0), 1, 5'h1f, 0, 0, 0, 0, 0, 0);
        idle(2, 5'h1f);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            ins_t ri;
            logic [4:0] ur;
            bit fl, v;
            ri = rnd_ins();
            ur = '0;
            for (int b = 0; b < 5; b++) ur[b] = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            v  = !fl && ($urandom_range(0, 9) < 7);
            step(ri, v, ur,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 7),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 7),
                 $urandom_range(0, 4) == 0, fl);
        end
        idle(3, 5'h1f);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
